seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised, iterative shift-add multiplier that produces a full-width product of two `WIDTH`-bit operands. It supports unsigned or two's-complement signed operation, selected per transaction. It is the sequential, handshaked successor to the team's combinational 8-bit unsigned/signed multipliers. It sits on datapaths where area matters more than latency, and it connects through valid/ready on both the operand and result sides.

## Interface
- `WIDTH`, 8, operand width in bits; legal range 2–32.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `A`  in  WIDTH  multiplicand; sampled only on the accept edge.
- `B`  in  WIDTH  multiplier; sampled only on the accept edge.
- `is_signed`  in  1  1 = treat `A`/`B` as two's complement, 0 = unsigned; sampled on the accept edge.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept operands.
- `Prod`  out  2*WIDTH  registered product.
- `out_valid`  out  1  `Prod` holds a new result.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- States: IDLE, BUSY, DONE. `in_ready` = (state == IDLE), combinational from state.
- IDLE: on an edge with `in_valid && in_ready` (the accept edge), the block does the following and moves to BUSY:
  - latch operand magnitudes: |A| and |B| when signed, else A and B;
  - latch the result sign `neg` = A[W-1]^B[W-1] when signed, else 0;
  - clear the accumulator;
  - set the bit counter to 0.
- BUSY: each edge processes one multiplier bit, LSB first. If the bit is 1, the shifted multiplicand is added into the 2*WIDTH accumulator. The multiplicand shifts left and the multiplier shifts right.
- BUSY ends after WIDTH edges. On the final edge:
  - `Prod` <= `neg` ? -acc_final : acc_final, truncated to 2*WIDTH;
  - `out_valid` <= 1;
  - state moves to DONE.
- DONE: `Prod` and `out_valid` are held until an edge with `out_ready`. On that edge `out_valid` <= 0 and the state returns to IDLE. No operands are accepted in DONE, even if `out_ready` is high.
- `Prod` keeps its last value after the handshake until the next result overwrites it.
- Width rules:
  - The magnitude of -2^(W-1) is 2^(W-1), which is representable as WIDTH-bit unsigned.
  - The worst-case signed product (-2^(W-1))² = 2^(2W-2) fits in 2*WIDTH bits.
  - The unsigned maximum (2^W-1)² fits in 2*WIDTH bits.
  - No overflow is possible.
- Zero operand: the block still takes the full WIDTH BUSY cycles. There is no early termination.

## Timing
- Reset values:
  - state = IDLE;
  - `Prod` = 0;
  - `out_valid` = 0;
  - `in_ready` = 1 from the first cycle after reset.
- Latency: `out_valid` rises on the WIDTH-th rising edge after the accept edge (8 cycles at the default).
- Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH BUSY, one DONE cycle with `out_ready` high, back in IDLE).
- `out_ready` held high before the result arrives: DONE lasts exactly one cycle.
- `out_ready` low: DONE persists indefinitely and `in_ready` stays 0.
- `A`, `B` and `is_signed` may change freely after the accept edge without affecting the result.
- `rst` during BUSY or DONE: on the next edge the block returns to the reset values. The in-flight result is discarded and `out_valid` is never asserted for it.
- `rst` and `in_valid` asserted on the same edge: reset wins and nothing is accepted.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined: signed mode is available as described above.
- `SEQ_MULT_SIGNED_EN` undefined:
  - the `is_signed` port remains but is ignored;
  - all operations are unsigned;
  - `neg` is constant 0;
  - the magnitude and negation logic is removed.

## Test plan
- WIDTH=8, unsigned: A=51, B=5 → `Prod`=255 (0x00FF), with `out_valid` rising exactly 8 edges after accept. Then A=16, B=16 → `Prod`=256.
- Signed, WIDTH=8, each operation checked separately:
  - A=0xCD (-51), B=5 → `Prod`=0xFF01 (-255).
  - A=16, B=0xF0 (-16) → `Prod`=0xFF00 (-256).
  - The same A=0xCD, B=5 pattern in unsigned mode → `Prod`=1025.
- Signed corner case: A=B=0x80 (-128) → `Prod`=0x4000 (16384). A=0x7F, B=0x80 → `Prod`=0xC080 (-16256).
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after `out_valid`; `Prod` stays stable and `in_ready` stays 0 while `in_valid` is held.
  - Raise `out_ready`; `out_valid` drops on that edge and the next operand pair is accepted one edge later.
- Reset mid-operation: accept A=200, B=3, assert `rst` on the 4th BUSY edge. Then:
  - `Prod`=0, `out_valid` stays 0 and `in_ready`=1 afterwards;
  - a new operation with A=7, B=9 returns 63.
- With `SEQ_MULT_SIGNED_EN` undefined: `is_signed`=1, A=0xCD, B=5 → `Prod`=1025. Also rerun the first scenario.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes on operands and result.
// Define SEQ_MULT_SIGNED_EN to enable two's-complement operation selected by is_signed.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 is_signed,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   Prod,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [PW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [PW-1:0]    acc_add_s;
    logic [PW-1:0]    prod_next_s;

    assign in_ready = (state_r == S_IDLE);

    // Accumulator plus the current partial product selected by the multiplier LSB.
    always_comb begin
        acc_add_s = acc_r;
        if (mplier_r[0]) begin
            acc_add_s = acc_r + mcand_r;
        end else begin
            acc_add_s = acc_r;
        end
    end

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_r;

    // |v| fits in WIDTH unsigned bits even for the most negative value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = ~v + WIDTH'(1);
        end else begin
            magnitude = v;
        end
    endfunction

    assign a_mag_s     = magnitude(A, is_signed);
    assign b_mag_s     = magnitude(B, is_signed);
    assign prod_next_s = neg_r ? (~acc_add_s + PW'(1)) : acc_add_s;

    // Result sign captured alongside the operand magnitudes.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_r <= 1'b0;
        end else if (state_r == S_IDLE && in_valid) begin
            neg_r <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
        end
    end
`else
    logic unused_is_signed_s;

    assign unused_is_signed_s = is_signed;
    assign a_mag_s            = A;
    assign b_mag_s            = B;
    assign prod_next_s        = acc_add_s;
`endif

    // Handshake FSM and shift-add datapath; one multiplier bit per BUSY edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            mcand_r   <= {PW{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            acc_r     <= {PW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            Prod      <= {PW{1'b0}};
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        acc_r    <= {PW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        state_r  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_r    <= acc_add_s;
                    mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        Prod      <= prod_next_s;
                        out_valid <= 1'b1;
                        state_r   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed, scoreboard-based bench for seq_multiplier at WIDTH=8.
// Expected products follow SEQ_MULT_SIGNED_EN: signed requests degrade to unsigned when it is undefined.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           is_signed;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] Prod;
    logic           out_valid;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] sb_q[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Prod      (Prod),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic        [15:0] ua;
        logic        [15:0] ub;
        logic               use_signed;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        ua = {8'd0, a};
        ub = {8'd0, b};
`ifdef SEQ_MULT_SIGNED_EN
        use_signed = s;
`else
        use_signed = s & 1'b0;
`endif
        if (use_signed) return 16'(sa * sb);
        else return 16'(ua * ub);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
        A         = a;
        B         = b;
        is_signed = s;
        in_valid  = 1'b1;
        sb_q.push_back(model(a, b, s));
    endtask

    task automatic wait_result(input string tag);
        int n;
        logic [15:0] exp;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, W);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
        check({tag, "_prod"}, Prod, exp);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
        out_ready = 1'b1;
        drive(a, b, s);
        tick();
        in_valid  = 1'b0;
        A         = ~a;
        B         = ~b;
        is_signed = ~s;
        check({tag, "_accepted"}, in_ready, 0);
        wait_result(tag);
        tick();
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        int highs;
        rst       = 1'b1;
        A         = 8'd0;
        B         = 8'd0;
        is_signed = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_prod", Prod, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);

        run_op(8'd51, 8'd5, 1'b0, "u51x5");
        run_op(8'd16, 8'd16, 1'b0, "u16x16");
        run_op(8'hCD, 8'd5, 1'b1, "s_m51x5");
        run_op(8'd16, 8'hF0, 1'b1, "s16x_m16");
        run_op(8'hCD, 8'd5, 1'b0, "u205x5");
        run_op(8'h80, 8'h80, 1'b1, "s_min_sq");
        run_op(8'h7F, 8'h80, 1'b1, "s_max_min");
        run_op(8'd0, 8'hFF, 1'b0, "zero");
        run_op(8'hFF, 8'hFF, 1'b0, "u_max_sq");
        run_op(8'hFF, 8'hFF, 1'b1, "s_m1_sq");
        run_op(8'd51, 8'd5, 1'b1, "s51x5");

        // Backpressure: result held while in_valid stays high with the next pair.
        out_ready = 1'b0;
        drive(8'd100, 8'd3, 1'b0);
        tick();
        A = 8'd9;
        B = 8'd11;
        is_signed = 1'b0;
        wait_result("bp_first");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_prod_hold", Prod, 16'd300);
            check("bp_valid_hold", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        sb_q.push_back(model(8'd9, 8'd11, 1'b0));
        tick();
        check("bp_valid_drop", out_valid, 0);
        check("bp_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", in_ready, 0);
        wait_result("bp_second");
        tick();
        check("bp_second_drop", out_valid, 0);

        // Reset on the 4th BUSY edge discards the in-flight result.
        out_ready = 1'b1;
        A         = 8'd200;
        B         = 8'd3;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_accepted", in_ready, 0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_prod", Prod, 0);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) highs++;
        end
        check("rst_mid_no_result", highs, 0);
        run_op(8'd7, 8'd9, 1'b0, "after_rst");

        // Reset and in_valid on the same edge: nothing accepted.
        A        = 8'd5;
        B        = 8'd5;
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid_ready", in_ready, 1);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) highs++;
        end
        check("rst_vs_valid_no_result", highs, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
